// File: rtl/elastic_pipeline_v5_0_pkg.sv
// Shared constants and helpers for the elastic pipeline family.
package elastic_pkg_v5_0;

  localparam int MAX_PIPE_STAGES = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/elastic_pipeline_v5_0_stage.sv
// One data+valid register. The data half only loads when the incoming valid
// is set, so bubbles never overwrite the held word.
module elastic_stage_v5_0 #(
  parameter int                  C_WIDTH     = 16,
  parameter logic [C_WIDTH-1:0]  C_SINIT_VAL = '0
) (
  input  logic               CLK,
  input  logic               SCLR,
  input  logic               ld,
  input  logic               vin,
  input  logic [C_WIDTH-1:0] din,
  output logic               vld,
  output logic [C_WIDTH-1:0] dat
);

  always_ff @(posedge CLK) begin
    if (SCLR) begin
      vld <= 1'b0;
      dat <= C_SINIT_VAL;
    end else if (ld) begin
      vld <= vin;
      if (vin) dat <= din;
    end
  end

endmodule

// File: rtl/elastic_pipeline_v5_0.sv
// Flow-controlled register pipeline with an input skid register so that
// D_READY is registered and never sees the combinational advance chain.
module elastic_pipeline_v5_0
  import elastic_pkg_v5_0::*;
#(
  parameter int                  C_WIDTH       = 16,
  parameter int                  C_PIPE_STAGES = 3,
  parameter logic [C_WIDTH-1:0]  C_SINIT_VAL   = '0,
  parameter int                  C_CNT_WIDTH   = 4
) (
  input  logic                   CLK,
  input  logic                   SCLR,
  input  logic [C_WIDTH-1:0]     D,
  input  logic                   D_VALID,
  output logic                   D_READY,
  output logic [C_WIDTH-1:0]     Q,
  output logic                   Q_VALID,
  input  logic                   Q_READY,
  output logic [C_CNT_WIDTH-1:0] OCCUPANCY
);

  localparam int N = C_PIPE_STAGES;

  if (N < 1 || N > MAX_PIPE_STAGES) begin : g_bad_stages
    $fatal(1, "elastic_pipeline_v5_0: C_PIPE_STAGES=%0d out of range 1..%0d", N, MAX_PIPE_STAGES);
  end
  if (C_CNT_WIDTH < clog2(N + 2)) begin : g_bad_cnt
    $fatal(1, "elastic_pipeline_v5_0: C_CNT_WIDTH=%0d cannot hold %0d", C_CNT_WIDTH, N + 1);
  end

  logic [N-1:0]              stg_v;
  logic [N-1:0]              adv;
  logic [N-1:0][C_WIDTH-1:0] stg_d;
  logic                      skid_v, skid_v_n, skid_ld, skid_wr;
  logic [C_WIDTH-1:0]        skid_d;
  logic                      in_xfer, out_xfer;
  logic [C_CNT_WIDTH-1:0]    occ;

  assign in_xfer  = D_VALID & D_READY;
  assign out_xfer = stg_v[N-1] & Q_READY;

  // A stage may advance if its successor advances or it holds a bubble.
  always_comb begin
    adv      = '0;
    adv[N-1] = Q_READY | ~stg_v[N-1];
    for (int i = N - 2; i >= 0; i--)
      adv[i] = adv[i+1] | ~stg_v[i];
  end

  // Skid takes D when stage 0 is blocked, or refills while it drains.
  assign skid_wr  = in_xfer & (~adv[0] | skid_v);
  assign skid_ld  = skid_wr | (adv[0] & skid_v);
  assign skid_v_n = skid_wr | (skid_v & ~adv[0]);

  elastic_stage_v5_0 #(.C_WIDTH(C_WIDTH), .C_SINIT_VAL(C_SINIT_VAL)) u_skid (
    .CLK(CLK), .SCLR(SCLR), .ld(skid_ld), .vin(skid_wr), .din(D),
    .vld(skid_v), .dat(skid_d)
  );

  for (genvar i = 0; i < N; i++) begin : g_stage
    if (i == 0) begin : g_head
      elastic_stage_v5_0 #(.C_WIDTH(C_WIDTH), .C_SINIT_VAL(C_SINIT_VAL)) u_stg (
        .CLK(CLK), .SCLR(SCLR), .ld(adv[0]), .vin(skid_v | in_xfer),
        .din(skid_v ? skid_d : D), .vld(stg_v[0]), .dat(stg_d[0])
      );
    end else begin : g_body
      elastic_stage_v5_0 #(.C_WIDTH(C_WIDTH), .C_SINIT_VAL(C_SINIT_VAL)) u_stg (
        .CLK(CLK), .SCLR(SCLR), .ld(adv[i]), .vin(stg_v[i-1]),
        .din(stg_d[i-1]), .vld(stg_v[i]), .dat(stg_d[i])
      );
    end
  end

  always_ff @(posedge CLK) begin
    if (SCLR) begin
      D_READY <= 1'b0;
      occ     <= '0;
    end else begin
      D_READY <= ~skid_v_n;
      if (in_xfer && !out_xfer)      occ <= occ + C_CNT_WIDTH'(1);
      else if (!in_xfer && out_xfer) occ <= occ - C_CNT_WIDTH'(1);
    end
  end

  assign Q         = stg_d[N-1];
  assign Q_VALID   = stg_v[N-1];
  assign OCCUPANCY = occ;

endmodule

// File: tb/tb_elastic_pipeline_v5_0.sv
// Bench for elastic_pipeline_v5_0: directed scenarios plus a queue-based
// model checked every cycle on the falling edge.
module tb_elastic_pipeline_v5_0;

  localparam int          W    = 16;
  localparam int          N    = 3;
  localparam logic [15:0] SINI = 16'h00A5;

  logic          CLK = 1'b0;
  logic          SCLR = 1'b1;
  logic [W-1:0]  D = '0;
  logic          D_VALID = 1'b0;
  logic          D_READY;
  logic [W-1:0]  Q;
  logic          Q_VALID;
  logic          Q_READY = 1'b0;
  logic [3:0]    OCCUPANCY;

  int checks = 0;
  int errors = 0;

  elastic_pipeline_v5_0 #(.C_WIDTH(W), .C_PIPE_STAGES(N), .C_SINIT_VAL(SINI), .C_CNT_WIDTH(4)) dut (
    .CLK(CLK), .SCLR(SCLR), .D(D), .D_VALID(D_VALID), .D_READY(D_READY),
    .Q(Q), .Q_VALID(Q_VALID), .Q_READY(Q_READY), .OCCUPANCY(OCCUPANCY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Model: the set of held words is just the accepted-but-not-emitted queue.
  logic [W-1:0] mq[$];
  bit           mdl_on   = 0;
  bit           rst_last = 0;
  bit           hold_prev = 0;
  logic [W-1:0] q_prev;

  always @(negedge CLK) begin
    if (mdl_on) begin
      chk("occupancy", 32'(OCCUPANCY), 32'(mq.size()));
      chk("d_ready", 32'(D_READY), 32'(!rst_last && mq.size() != N + 1));
      if (Q_VALID === 1'b1 && mq.size() == 0) chk("q_valid_empty", 32'(Q_VALID), 32'd0);
      if (hold_prev) begin
        chk("hold_q", 32'(Q), 32'(q_prev));
        chk("hold_qv", 32'(Q_VALID), 32'd1);
      end
    end
    if (SCLR) begin
      mq.delete();
      rst_last  = 1;
      mdl_on    = 1;
      hold_prev = 0;
    end else if (mdl_on) begin
      if (Q_VALID && Q_READY) begin
        if (mq.size() == 0) chk("pop_empty", 32'd1, 32'd0);
        else chk("order", 32'(Q), 32'(mq.pop_front()));
      end
      if (D_VALID && D_READY) mq.push_back(D);
      rst_last  = 0;
      hold_prev = Q_VALID && !Q_READY;
      q_prev    = Q;
    end
  end

  initial begin
    int acc, cyc;
    bit was;

    // 1 reset
    tick(); tick();
    chk("rst_q", 32'(Q), 32'(SINI));
    chk("rst_qv", 32'(Q_VALID), 32'd0);
    chk("rst_occ", 32'(OCCUPANCY), 32'd0);
    chk("rst_drdy", 32'(D_READY), 32'd0);
    SCLR = 1'b0;
    #1 chk("drdy_pre_edge", 32'(D_READY), 32'd0);
    tick();
    chk("drdy_rise", 32'(D_READY), 32'd1);

    // 2 latency
    Q_READY = 1'b1;
    D = 16'h1111; D_VALID = 1'b1;
    tick();
    D_VALID = 1'b0;
    chk("lat_occ1", 32'(OCCUPANCY), 32'd1);
    chk("lat_qv0", 32'(Q_VALID), 32'd0);
    tick();
    chk("lat_qv1", 32'(Q_VALID), 32'd0);
    tick();
    chk("lat_qv2", 32'(Q_VALID), 32'd1);
    chk("lat_q", 32'(Q), 32'h1111);
    tick();
    chk("lat_occ0", 32'(OCCUPANCY), 32'd0);
    chk("lat_qv_end", 32'(Q_VALID), 32'd0);

    // 3 stream 0x0001..0x0040
    for (int i = 0; i < 66; i++) begin
      D_VALID = (i < 64);
      D = 16'(i + 1);
      if (i < 64) chk("stream_drdy", 32'(D_READY), 32'd1);
      tick();
      if (i >= 2) begin
        chk("stream_qv", 32'(Q_VALID), 32'd1);
        chk("stream_q", 32'(Q), 32'(i - 1));
      end
    end
    D_VALID = 1'b0;
    tick();

    // 4 fill with Q_READY low, then release
    Q_READY = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      D = 16'h0100 + 16'(acc);
      D_VALID = 1'b1;
      was = D_READY;
      tick();
      if (was) acc++;
    end
    D_VALID = 1'b0;
    chk("fill_acc", 32'(acc), 32'd4);
    chk("fill_drdy", 32'(D_READY), 32'd0);
    chk("fill_occ", 32'(OCCUPANCY), 32'd4);
    chk("fill_q", 32'(Q), 32'h0100);
    chk("fill_qv", 32'(Q_VALID), 32'd1);
    Q_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_qv", 32'(Q_VALID), 32'd1);
      chk("drain_q", 32'(Q), 32'h0100 + 32'(k));
      tick();
      if (k == 0) chk("drain_drdy", 32'(D_READY), 32'd1);
    end
    chk("drain_qv_end", 32'(Q_VALID), 32'd0);
    chk("drain_occ", 32'(OCCUPANCY), 32'd0);

    // 5 random traffic
    acc = 0; cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      D_VALID = 1'($urandom_range(0, 1));
      D       = 16'($urandom);
      Q_READY = 1'($urandom_range(0, 1));
      was = D_VALID & D_READY;
      tick();
      if (was) acc++;
      cyc++;
    end
    chk("rand_words", 32'(acc), 32'd10000);
    D_VALID = 1'b0;
    Q_READY = 1'b1;
    cyc = 0;
    while (mq.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    chk("rand_drained", 32'(mq.size()), 32'd0);
    chk("rand_occ", 32'(OCCUPANCY), 32'd0);

    // 6 SCLR mid-flight with three words held
    Q_READY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      D = 16'h0A01 + 16'(k);
      D_VALID = 1'b1;
      tick();
    end
    D_VALID = 1'b0;
    chk("mid_occ3", 32'(OCCUPANCY), 32'd3);
    SCLR = 1'b1;
    tick();
    SCLR = 1'b0;
    chk("mid_qv", 32'(Q_VALID), 32'd0);
    chk("mid_occ", 32'(OCCUPANCY), 32'd0);
    chk("mid_q", 32'(Q), 32'(SINI));
    Q_READY = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("mid_no_ghost", 32'(Q_VALID), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
